// File: rtl/h264_chroma_dc_hadamard_if.sv
// Bus between the chroma DC source, the 2x2 chroma DC Hadamard stage and the DC quantiser.
// The source/sink side uses master and the transform uses slave.
interface h264_chroma_dc_hadamard_if #(
  parameter int DW = 16,
  parameter int OW = DW + 2
);
  logic                 NEWLINE;
  logic                 DCSTROBEI;
  logic signed [DW-1:0] DCDATAI;
  logic                 READYO;
  logic                 STROBEO;
  logic signed [OW-1:0] DATAO;
  logic [1:0]           IDXO;
  logic                 CRCBO;
  logic                 OVERRUN;

  modport master (
    output NEWLINE, DCSTROBEI, DCDATAI, READYO,
    input  STROBEO, DATAO, IDXO, CRCBO, OVERRUN
  );

  modport slave (
    input  NEWLINE, DCSTROBEI, DCDATAI, READYO,
    output STROBEO, DATAO, IDXO, CRCBO, OVERRUN
  );
endinterface

// File: rtl/h264_chroma_dc_hadamard.sv
// 2x2 Hadamard transform of chroma DC sums: double-buffered quad capture, one-cycle
// butterfly, then four coefficients emitted under READYO flow control.
module h264_chroma_dc_hadamard #(
  parameter int DW = 16,
  parameter int OW = DW + 2
) (
  input  logic                    CLK2,
  input  logic                    RESET_N,
  h264_chroma_dc_hadamard_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  logic signed [DW-1:0] r_bank_d [2][4];
  logic [1:0]           r_full;
  logic [1:0]           r_btag;
  logic [1:0]           r_wptr;
  logic                 r_wbank;
  logic                 r_tag;
  logic                 r_rbank;
  logic [1:0]           r_optr;
  logic signed [OW-1:0] r_f [4];
  state_t               r_state;
  state_t               w_state_nxt;

  logic                 r_strobe;
  logic signed [OW-1:0] r_data;
  logic [1:0]           r_idx;
  logic                 r_crcb;
  logic                 r_overrun;

  logic                 w_wfull;
  logic                 w_calc;
  logic                 w_emit;
  logic                 w_release;
  logic signed [OW-1:0] w_e [4];

  assign w_wfull = r_full[r_wbank];

  // Write-side control; a write aimed at a full bank still advances the grouping so the stream stays aligned.
  always_ff @(posedge CLK2) begin
    if (!RESET_N) begin
      r_full    <= 2'b00;
      r_btag    <= 2'b00;
      r_wptr    <= 2'd0;
      r_wbank   <= 1'b0;
      r_tag     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_release) begin
        r_full[r_rbank] <= 1'b0;
      end
      if (bus.DCSTROBEI) begin
        r_wptr <= r_wptr + 2'd1;
        if (w_wfull) begin
          r_overrun <= 1'b1;
        end
        if (r_wptr == 2'd3) begin
          r_tag   <= ~r_tag;
          r_wbank <= ~r_wbank;
          if (!w_wfull) begin
            r_full[r_wbank] <= 1'b1;
            r_btag[r_wbank] <= r_tag;
          end
        end
      end else if (bus.NEWLINE) begin
        r_wptr <= 2'd0;
        r_tag  <= 1'b0;
      end
    end
  end

  // Sample storage is data only and carries no reset.
  always_ff @(posedge CLK2) begin
    if (RESET_N && bus.DCSTROBEI && !w_wfull) begin
      r_bank_d[r_wbank][r_wptr] <= bus.DCDATAI;
    end
  end

  // Sign-extend the read bank before the butterfly so the sums cannot wrap.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_e[i] = OW'(r_bank_d[r_rbank][i]);
    end
  end

  // Hadamard butterfly, captured once per group.
  always_ff @(posedge CLK2) begin
    if (w_calc) begin
      r_f[0] <= w_e[0] + w_e[1] + w_e[2] + w_e[3];
      r_f[1] <= w_e[0] - w_e[1] + w_e[2] - w_e[3];
      r_f[2] <= w_e[0] + w_e[1] - w_e[2] - w_e[3];
      r_f[3] <= w_e[0] - w_e[1] - w_e[2] + w_e[3];
    end
  end

  // Output FSM state register.
  always_ff @(posedge CLK2) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_full[r_rbank]) w_state_nxt = S_CALC;
        else                 w_state_nxt = S_IDLE;
      end
      S_CALC: w_state_nxt = S_EMIT;
      S_EMIT: begin
        if (bus.READYO && (r_optr == 2'd3)) w_state_nxt = S_IDLE;
        else                                w_state_nxt = S_EMIT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output FSM decode.
  always_comb begin
    w_calc    = (r_state == S_CALC);
    w_emit    = (r_state == S_EMIT) && bus.READYO;
    w_release = w_emit && (r_optr == 2'd3);
  end

  // Coefficient output registers; values hold while the sink stalls.
  always_ff @(posedge CLK2) begin
    if (!RESET_N) begin
      r_strobe <= 1'b0;
      r_data   <= '0;
      r_idx    <= 2'd0;
      r_crcb   <= 1'b0;
      r_optr   <= 2'd0;
      r_rbank  <= 1'b0;
    end else begin
      r_strobe <= w_emit;
      if (w_emit) begin
        r_data <= r_f[r_optr];
        r_idx  <= r_optr;
        r_crcb <= r_btag[r_rbank];
        r_optr <= r_optr + 2'd1;
      end
      if (w_release) begin
        r_rbank <= ~r_rbank;
      end
    end
  end

  assign bus.STROBEO = r_strobe;
  assign bus.DATAO   = r_data;
  assign bus.IDXO    = r_idx;
  assign bus.CRCBO   = r_crcb;
  assign bus.OVERRUN = r_overrun;

endmodule
